obstacle_lane_engine: RTL and testbench

//  Parametrised N-lane obstacle mover for the road/crossing game; next generation of the fixed 4-car mover.

---
 rtl/obstacle_lane_engine_pkg.sv | 27 ++
 rtl/obstacle_lane_step.sv | 46 ++++
 rtl/obstacle_lane_engine.sv | 92 +++++++++
 tb/tb_obstacle_lane_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_lane_engine_pkg.sv
// Shared definitions for the obstacle lane engine: screen geometry defaults,
// score-to-speed thresholds and lane direction encodings.
package obstacle_lane_engine_pkg;

  localparam int H_VISIBLE_AREA_DEF = 640;
  localparam int TILE_SIZE_DEF      = 32;
  localparam int MAX_X_DEF          = H_VISIBLE_AREA_DEF - TILE_SIZE_DEF;
  localparam int X_WIDTH_DEF        = 10;

  localparam logic [3:0] SCORE_SHIFT1 = 4'd4;
  localparam logic [3:0] SCORE_SHIFT2 = 4'd7;
  localparam logic [3:0] SCORE_SHIFT3 = 4'd10;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  // Each speed level halves the tick period.
  function automatic logic [1:0] score_to_shift(input logic [3:0] score);
    if (score >= SCORE_SHIFT3)      return 2'd3;
    else if (score >= SCORE_SHIFT2) return 2'd2;
    else if (score >= SCORE_SHIFT1) return 2'd1;
    else                            return 2'd0;
  endfunction

endpackage

// File: rtl/obstacle_lane_step.sv
// One obstacle lane: holds its X position and steps it with modular wrap
// across [0, MAX_X) whenever step_en is high.
module obstacle_lane_step
  import obstacle_lane_engine_pkg::*;
#(
  parameter int                 X_WIDTH = X_WIDTH_DEF,
  parameter int                 MAX_X   = MAX_X_DEF,
  parameter logic [3:0]         STEP    = 4'd1,
  parameter logic [X_WIDTH-1:0] RESET_X = '0
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               step_en,
  input  dir_e               dir,
  output logic [X_WIDTH-1:0] x
);

  localparam int XW1 = X_WIDTH + 1;
  localparam logic [X_WIDTH:0] MAX_W  = XW1'(MAX_X);
  localparam logic [X_WIDTH:0] STEP_W = XW1'(STEP);

  logic [X_WIDTH:0] x_w;
  logic [X_WIDTH:0] fwd_sum;
  logic [X_WIDTH:0] next_x;

  // One extra bit keeps X+S and X+MAX_X-S from overflowing before the wrap.
  always_comb begin
    x_w     = {1'b0, x};
    fwd_sum = x_w + STEP_W;
    next_x  = fwd_sum;
    if (dir == DIR_REV) begin
      next_x = (x_w < STEP_W) ? (x_w + MAX_W - STEP_W) : (x_w - STEP_W);
    end else if (fwd_sum >= MAX_W) begin
      next_x = fwd_sum - MAX_W;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      x <= RESET_X;
    end else if (step_en) begin
      x <= X_WIDTH'(next_x);
    end
  end

endmodule

// File: rtl/obstacle_lane_engine.sv
// N-lane obstacle mover: score-scaled tick prescaler, direction register and
// per-lane wrapped stepping. OBSTACLE_LANE_PAUSE_EN adds i_Pause (hold positions, keep ticking).
module obstacle_lane_engine
  import obstacle_lane_engine_pkg::*;
#(
  parameter int                     NUM_LANES        = 4,
  parameter int                     X_WIDTH          = X_WIDTH_DEF,
  parameter int                     C_BASE_CAR_SPEED = 781250,
  parameter int                     H_VISIBLE_AREA   = H_VISIBLE_AREA_DEF,
  parameter int                     TILE_SIZE        = TILE_SIZE_DEF,
  parameter logic [NUM_LANES*4-1:0] LANE_STEPS       = 16'h1242
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_Enable,
  input  logic                           i_Level_Up,
  input  logic [NUM_LANES-1:0]           i_Reverse,
  input  logic [3:0]                     i_Score,
`ifdef OBSTACLE_LANE_PAUSE_EN
  input  logic                           i_Pause,
`endif
  output logic [NUM_LANES*X_WIDTH-1:0]   o_Car_X,
  output logic [NUM_LANES-1:0]           o_Reverse,
  output logic                           o_Tick
);

  localparam int MAX_X = H_VISIBLE_AREA - TILE_SIZE;
  localparam int CNT_W = $clog2(C_BASE_CAR_SPEED);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_last;
  logic [1:0]       shift;
  logic             period_end;
  logic             move;

  always_comb begin
    count_last = CNT_W'(C_BASE_CAR_SPEED - 1);
    case (shift)
      2'd0:    count_last = CNT_W'(C_BASE_CAR_SPEED - 1);
      2'd1:    count_last = CNT_W'((C_BASE_CAR_SPEED >> 1) - 1);
      2'd2:    count_last = CNT_W'((C_BASE_CAR_SPEED >> 2) - 1);
      default: count_last = CNT_W'((C_BASE_CAR_SPEED >> 3) - 1);
    endcase
  end

  assign period_end = i_Enable && (count == count_last);

`ifdef OBSTACLE_LANE_PAUSE_EN
  assign move = period_end && !i_Pause;
`else
  assign move = period_end;
`endif

  // Shift is only re-sampled at a period boundary so no period in flight changes length.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count     <= '0;
      shift     <= 2'd0;
      o_Tick    <= 1'b0;
      o_Reverse <= '0;
    end else begin
      o_Tick <= period_end;
      if (i_Level_Up) begin
        o_Reverse <= i_Reverse;
      end
      if (i_Enable) begin
        if (period_end) begin
          count <= '0;
          shift <= score_to_shift(i_Score);
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    obstacle_lane_step #(
      .X_WIDTH (X_WIDTH),
      .MAX_X   (MAX_X),
      .STEP    (LANE_STEPS[4*i +: 4]),
      .RESET_X (X_WIDTH'((i * TILE_SIZE) % MAX_X))
    ) u_step (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .step_en (move),
      .dir     (dir_e'(o_Reverse[i])),
      .x       (o_Car_X[i*X_WIDTH +: X_WIDTH])
    );
  end

endmodule

// File: tb/tb_obstacle_lane_engine.sv
// Directed bench for obstacle_lane_engine with a queue of predicted lane positions
// popped on every o_Tick; small geometry (period 16, MAX_X 56).
module tb_obstacle_lane_engine;

  localparam int NUM_LANES = 4;
  localparam int X_WIDTH   = 10;
  localparam int MAX_X     = 56;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        levelUp;
  logic [3:0]  reverse;
  logic [3:0]  score;
`ifdef OBSTACLE_LANE_PAUSE_EN
  logic        pause;
`endif
  logic [39:0] carX;
  logic [3:0]  revOut;
  logic        tick;

  int errors = 0;
  int checks = 0;

  int          mx[4];
  logic [3:0]  mdir;
  int          steps[4] = '{2, 4, 2, 1};
  logic [39:0] sbQueue[$];

  always #5 clk = ~clk;

  obstacle_lane_engine #(
    .NUM_LANES        (NUM_LANES),
    .X_WIDTH          (X_WIDTH),
    .C_BASE_CAR_SPEED (16),
    .H_VISIBLE_AREA   (64),
    .TILE_SIZE        (8),
    .LANE_STEPS       (16'h1242)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (reset),
    .i_Enable   (enable),
    .i_Level_Up (levelUp),
    .i_Reverse  (reverse),
    .i_Score    (score),
`ifdef OBSTACLE_LANE_PAUSE_EN
    .i_Pause    (pause),
`endif
    .o_Car_X    (carX),
    .o_Reverse  (revOut),
    .o_Tick     (tick)
  );

  task automatic applyStimulus(input logic en, input logic lu, input logic [3:0] rev, input logic [3:0] sc);
    enable  = en;
    levelUp = lu;
    reverse = rev;
    score   = sc;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [39:0] packModel();
    logic [39:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*10 +: 10] = 10'(mx[i]);
    return v;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 4; i++) mx[i] = (i * 8) % MAX_X;
    mdir = 4'b0000;
  endtask

  task automatic predictTick();
    for (int i = 0; i < 4; i++) begin
      if (mdir[i]) mx[i] = (mx[i] - steps[i] + MAX_X) % MAX_X;
      else         mx[i] = (mx[i] + steps[i]) % MAX_X;
    end
    sbQueue.push_back(packModel());
  endtask

  task automatic predictHold();
    sbQueue.push_back(packModel());
  endtask

  // Waits (bounded) for the next o_Tick, then checks its timing and the predicted positions.
  task automatic expectTick(input string tag, input int expCycles);
    int n;
    logic [39:0] expX;
    n = 0;
    while (n < expCycles + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (tick) break;
    end
    checkOutput({tag, "_period"}, 64'(n), 64'(expCycles));
    expX = (sbQueue.size() > 0) ? sbQueue.pop_front() : 'x;
    checkOutput({tag, "_x"}, 64'(carX), 64'(expX));
  endtask

  initial begin
    logic sawTick;
    reset = 1'b1;
`ifdef OBSTACLE_LANE_PAUSE_EN
    pause = 1'b0;
`endif
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'd0);
    resetModel();
    waitCycles(3);
    checkOutput("reset_x", 64'(carX), 64'(packModel()));
    checkOutput("reset_tick", 64'(tick), 64'd0);
    checkOutput("reset_dir", 64'(revOut), 64'd0);
    reset = 1'b0;

    predictTick();
    expectTick("first", 16);
    waitCycles(1);
    checkOutput("tick_width", 64'(tick), 64'd0);
    predictTick();
    expectTick("second", 15);

    $display("[TB] score changes");
    waitCycles(5);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'd10);
    predictTick();
    expectTick("score_hold", 11);
    predictTick();
    expectTick("fast1", 2);
    predictTick();
    expectTick("fast2", 2);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'd5);
    predictTick();
    expectTick("score5_inflight", 2);
    predictTick();
    expectTick("mid8", 8);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'd10);
    predictTick();
    expectTick("mid8b", 8);
    for (int k = 0; k < 40; k++) begin
      predictTick();
      expectTick("fwd_run", 2);
    end

    $display("[TB] reverse lanes");
    applyStimulus(1'b1, 1'b1, 4'b1001, 4'd10);
    waitCycles(1);
    levelUp = 1'b0;
    checkOutput("rev_load", 64'(revOut), 64'b1001);
    mdir = 4'b1001;
    predictTick();
    expectTick("rev_first", 1);
    for (int k = 0; k < 60; k++) begin
      predictTick();
      expectTick("rev_run", 2);
    end

    $display("[TB] level-up on tick cycle");
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 4'b0110, 4'd10);
    predictTick();
    expectTick("lvl_on_tick", 1);
    levelUp = 1'b0;
    checkOutput("lvl_on_tick_dir", 64'(revOut), 64'b0110);
    mdir = 4'b0110;
    predictTick();
    expectTick("new_dir", 2);

    $display("[TB] freeze");
    waitCycles(1);
    enable = 1'b0;
    sawTick = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        levelUp = 1'b1;
        reverse = 4'b0100;
      end else begin
        levelUp = 1'b0;
      end
      waitCycles(1);
      sawTick = sawTick | tick;
    end
    levelUp = 1'b0;
    checkOutput("freeze_tick", 64'(sawTick), 64'd0);
    checkOutput("freeze_x", 64'(carX), 64'(packModel()));
    checkOutput("freeze_dir", 64'(revOut), 64'b0100);
    mdir = 4'b0100;
    enable = 1'b1;
    predictTick();
    expectTick("unfreeze", 1);

    $display("[TB] reset mid-period");
    score = 4'd0;
    predictTick();
    expectTick("to_slow", 2);
    waitCycles(5);
    score = 4'd10;
    reset = 1'b1;
    waitCycles(1);
    resetModel();
    checkOutput("midreset_x", 64'(carX), 64'(packModel()));
    checkOutput("midreset_tick", 64'(tick), 64'd0);
    checkOutput("midreset_dir", 64'(revOut), 64'd0);
    reset = 1'b0;
    predictTick();
    expectTick("post_reset", 16);
    predictTick();
    expectTick("post_reset_fast", 2);

`ifdef OBSTACLE_LANE_PAUSE_EN
    $display("[TB] pause");
    pause = 1'b1;
    predictHold();
    expectTick("pause1", 2);
    predictHold();
    expectTick("pause2", 2);
    pause = 1'b0;
    predictTick();
    expectTick("resume", 2);
`endif

    checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
